rr_grant_seq: RTL and testbench

Round-robin grant sequencer for eight requesters; it sits directly upstream of the 3-to-8 one-hot decoder. It arbitrates `req[7:0]` and holds one grant until that grant is released. It presents the winner as a binary index `gnt_idx` plus a qualifying `gnt_en`, which drive the decoder's select and enable inputs directly, so the decoder output is the one-hot grant vector.

---
 rtl/rr_grant_pkg.sv | 21 ++
 rtl/rr_prio_pick.sv | 31 +++
 rtl/rr_grant_seq.sv | 135 +++++++++++++
 tb/tb_rr_grant_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_pkg.sv
// rr_grant_pkg: shared definitions for the round-robin grant sequencer.
//   rr_state_t  : sequencer FSM states (IDLE, GRANT)
//   RR_N_REQ    : default requester count
//   RR_IDX_W    : default grant index width
//   rr_next_idx : modulo-wrap increment of a requester index
package rr_grant_pkg;

    localparam int unsigned RR_N_REQ = 8;
    localparam int unsigned RR_IDX_W = 3;

    typedef enum logic {
        IDLE,
        GRANT
    } rr_state_t;

    function automatic int unsigned rr_next_idx(input int unsigned idx,
                                                input int unsigned n = RR_N_REQ);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// rr_prio_pick: combinational rotated priority search.
// Ports:
//   req     in  N_REQ : request lines
//   ptr     in  IDX_W : index holding the highest priority
//   win_idx out IDX_W : first set request scanning ptr, ptr+1, ... (wrapping)
//   any_req out 1     : at least one request is set (win_idx valid)
module rr_prio_pick
    import rr_grant_pkg::*;
#(
    parameter int unsigned N_REQ = RR_N_REQ,
    parameter int unsigned IDX_W = RR_IDX_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             any_req
);

    // Scan from the farthest offset down to offset 0 so the closest set bit
    // to ptr is the last one written and therefore wins.
    always_comb begin
        win_idx = '0;
        any_req = |req;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req[ptr + IDX_W'(i)]) begin
                win_idx = ptr + IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_grant_seq.sv
// rr_grant_seq: round-robin grant sequencer for N_REQ requesters. Holds one
// grant until it is released or the holder drops its request; the winner is
// presented as a binary index plus enable for a downstream one-hot decoder.
// Optional feature macro: RR_GRANT_TIMEOUT_EN (hold timeout, adds the
// TIMEOUT_CYCLES parameter and the timeout port).
// Ports:
//   clk         in  1     : clock, rising edge
//   reset       in  1     : synchronous, active-high
//   req         in  N_REQ : level-sensitive request lines
//   release_gnt in  1     : current holder is done (release is a reserved word)
//   gnt_idx     out IDX_W : registered index of the granted requester
//   gnt_en      out 1     : registered, gnt_idx is valid
//   timeout     out 1     : one-cycle pulse on forced release (macro only)
module rr_grant_seq
    import rr_grant_pkg::*;
#(
    parameter int unsigned N_REQ = RR_N_REQ,
    parameter int unsigned IDX_W = RR_IDX_W
`ifdef RR_GRANT_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             release_gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_en
`ifdef RR_GRANT_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    rr_state_t        state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_en_q, gnt_en_d;
    logic [IDX_W-1:0] win_idx;
    logic             any_req;

`ifdef RR_GRANT_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic        expired;

    // cnt_q counts completed GRANT cycles, so the last allowed cycle is T-1.
    assign expired = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`endif

    rr_prio_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win_idx (win_idx),
        .any_req (any_req)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        gnt_en_d  = gnt_en_q;
`ifdef RR_GRANT_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                gnt_en_d = 1'b0;
                if (any_req) begin
                    gnt_idx_d = win_idx;
                    gnt_en_d  = 1'b1;
                    state_d   = GRANT;
`ifdef RR_GRANT_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            GRANT: begin
                // Explicit release or request drop beats timeout expiry.
                if (release_gnt || !req[gnt_idx_q]) begin
                    gnt_en_d = 1'b0;
                    ptr_d    = IDX_W'(rr_next_idx(32'(gnt_idx_q), N_REQ));
                    state_d  = IDLE;
`ifdef RR_GRANT_TIMEOUT_EN
                end else if (expired) begin
                    gnt_en_d  = 1'b0;
                    ptr_d     = IDX_W'(rr_next_idx(32'(gnt_idx_q), N_REQ));
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            gnt_en_q  <= 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_en_q  <= gnt_en_d;
`ifdef RR_GRANT_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gnt_idx = gnt_idx_q;
    assign gnt_en  = gnt_en_q;
`ifdef RR_GRANT_TIMEOUT_EN
    assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_rr_grant_seq.sv
// tb_rr_grant_seq: directed and randomized check of rr_grant_seq against a
// behavioural model. Timeout checks are included when RR_GRANT_TIMEOUT_EN is
// defined (TIMEOUT_CYCLES=4).
module tb_rr_grant_seq;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       release_gnt;
    logic [2:0] gnt_idx;
    logic       gnt_en;
    logic       timeout;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state (updated at the rising edge).
    int m_ptr = 0;
    int m_idx = 0;
    int m_held = 0;
    bit m_en = 1'b0;
    bit m_to = 1'b0;

    always #5 clk = ~clk;

    rr_grant_seq #(
`ifdef RR_GRANT_TIMEOUT_EN
        .TIMEOUT_CYCLES (TO),
`endif
        .N_REQ (8),
        .IDX_W (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .release_gnt (release_gnt),
        .gnt_idx     (gnt_idx),
        .gnt_en      (gnt_en)
`ifdef RR_GRANT_TIMEOUT_EN
        ,
        .timeout     (timeout)
`endif
    );

`ifndef RR_GRANT_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

    // Model: a grant is a holder index plus a count of cycles it has been held.
    always @(posedge clk) begin : model
        int  p, ix, h, cand;
        bit  e, t, found, done;
        p = m_ptr; ix = m_idx; h = m_held; e = m_en; t = 1'b0;
        if (reset) begin
            p = 0; ix = 0; h = 0; e = 1'b0;
        end else if (!e) begin
            found = 1'b0;
            for (int o = 0; o < 8; o++) begin
                cand = (p + o) % 8;
                if (!found && req[cand]) begin
                    found = 1'b1;
                    ix = cand;
                end
            end
            if (found) begin
                e = 1'b1;
                h = 0;
            end
        end else begin
            h = h + 1;
            done = release_gnt || !req[ix];
`ifdef RR_GRANT_TIMEOUT_EN
            if (!done && h == TO) begin
                done = 1'b1;
                t = 1'b1;
            end
`endif
            if (done) begin
                e = 1'b0;
                p = (ix + 1) % 8;
            end
        end
        m_ptr  <= p;
        m_idx  <= ix;
        m_held <= h;
        m_en   <= e;
        m_to   <= t;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic tick();
        @(negedge clk);
        chk("model_gnt_en", 32'(gnt_en), 32'(m_en));
        chk("model_gnt_idx", 32'(gnt_idx), 32'(m_idx));
`ifdef RR_GRANT_TIMEOUT_EN
        chk("model_timeout", 32'(timeout), 32'(m_to));
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = 8'h00;
        release_gnt = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req = 8'h00;
        release_gnt = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset then single request, pointer advance, wrap priority.
        tick();
        chk("rst_gnt_en", 32'(gnt_en), 0);
        chk("rst_gnt_idx", 32'(gnt_idx), 0);
        chk("rst_timeout", 32'(timeout), 0);
        reset = 1'b0;
        req = 8'h10;
        tick();
        chk("single_idx", 32'(gnt_idx), 4);
        chk("single_en", 32'(gnt_en), 1);
        release_gnt = 1'b1;
        tick();
        chk("release_en", 32'(gnt_en), 0);
        chk("release_idx_kept", 32'(gnt_idx), 4);
        release_gnt = 1'b0;
        req = 8'hFF;
        tick();
        chk("ptr5_idx", 32'(gnt_idx), 5);
        req = 8'h00;
        tick();
        chk("drop5_en", 32'(gnt_en), 0);
        req = 8'h21;
        tick();
        chk("wrap_idx", 32'(gnt_idx), 0);
        chk("wrap_en", 32'(gnt_en), 1);

        // Rotation with release every GRANT cycle.
        do_reset();
        req = 8'hFF;
        release_gnt = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("rot_en", 32'(gnt_en), 1);
            chk("rot_idx", 32'(gnt_idx), 32'(k % 8));
            tick();
            chk("rot_bubble", 32'(gnt_en), 0);
        end

        // Request drop by the holder.
        do_reset();
        req = 8'h08;
        tick();
        chk("drop_grant_idx", 32'(gnt_idx), 3);
        req = 8'h00;
        tick();
        chk("drop_en", 32'(gnt_en), 0);
        req = 8'h08;
        tick();
        chk("regrant_idx", 32'(gnt_idx), 3);
        chk("regrant_en", 32'(gnt_en), 1);
        release_gnt = 1'b1;
        tick();
        release_gnt = 1'b0;
        req = 8'h18;
        tick();
        chk("ptr4_idx", 32'(gnt_idx), 4);

        // Reset mid-grant.
        do_reset();
        req = 8'h40;
        tick();
        chk("mid_grant_idx", 32'(gnt_idx), 6);
        reset = 1'b1;
        req = 8'h41;
        tick();
        chk("mid_rst_en", 32'(gnt_en), 0);
        reset = 1'b0;
        tick();
        chk("mid_rst_regrant", 32'(gnt_idx), 0);
        chk("mid_rst_regrant_en", 32'(gnt_en), 1);

`ifdef RR_GRANT_TIMEOUT_EN
        // Forced release after TO cycles, then release on the expiry cycle.
        do_reset();
        req = 8'h02;
        for (int c = 0; c < TO; c++) begin
            tick();
            chk("to_hold_en", 32'(gnt_en), 1);
            chk("to_hold_pulse", 32'(timeout), 0);
        end
        tick();
        chk("to_fall_en", 32'(gnt_en), 0);
        chk("to_pulse", 32'(timeout), 1);
        tick();
        chk("to_pulse_width", 32'(timeout), 0);
        chk("to_regrant_idx", 32'(gnt_idx), 1);
        tick();
        tick();
        tick();
        chk("to_cycle4_en", 32'(gnt_en), 1);
        release_gnt = 1'b1;
        tick();
        chk("to_rel_en", 32'(gnt_en), 0);
        chk("to_rel_no_pulse", 32'(timeout), 0);
        release_gnt = 1'b0;
`endif

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 8'($urandom) & 8'($urandom);
            end
            release_gnt = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
